// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single L2 port between the I-cache and D-cache miss paths.
// One line transfer at a time. The D-cache has priority, and a starvation counter forces an
// I grant after STARVE_LIMIT consecutive contested D grants. All L2-side outputs and
// responses are registered.
// Optional build macro: ARB_PERF_CNT_EN adds grant/contention performance counters.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned LINE_W       = 128,
  parameter int unsigned STARVE_LIMIT = 4
`ifdef ARB_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W        = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt,
  output logic [CNT_W-1:0]  contend_cnt
`endif
);

  localparam int unsigned            StarveW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0]     StarveMax = StarveW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StResp} state_e;

  state_e              state_q, state_d;
  logic                d_req, grant_i, grant_d;
  logic                l2_read_q, l2_read_d, l2_write_q, l2_write_d;
  logic [ADDR_W-1:0]   l2_addr_q, l2_addr_d;
  logic [LINE_W-1:0]   l2_wdata_q, l2_wdata_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                i_resp_q, i_resp_d, d_resp_q, d_resp_d;
  logic [StarveW-1:0]  starve_q, starve_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state and arbitration; grants only happen in IDLE
  always_comb begin
    d_req   = d_mem_read | d_mem_write;
    grant_i = 1'b0;
    grant_d = 1'b0;
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (i_mem_read && (!d_req || starve_q == StarveMax)) begin
          grant_i = 1'b1;
          state_d = StGrantI;
        end else if (d_req) begin
          grant_d = 1'b1;
          state_d = StGrantD;
        end
      end
      StGrantI, StGrantD: if (l2_resp) state_d = StResp;
      StResp:             state_d = StIdle;
      default:            state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs, latches and starvation counter
  always_comb begin
    l2_read_d  = l2_read_q;
    l2_write_d = l2_write_q;
    l2_addr_d  = l2_addr_q;
    l2_wdata_d = l2_wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    starve_d   = starve_q;
    i_resp_d   = 1'b0;
    d_resp_d   = 1'b0;
    if (grant_i) begin
      l2_read_d  = 1'b1;
      l2_write_d = 1'b0;
      l2_addr_d  = i_mem_addr;
      starve_d   = '0;
    end
    if (grant_d) begin
      // A simultaneous read+write is served as the writeback first
      l2_read_d  = ~d_mem_write;
      l2_write_d = d_mem_write;
      l2_addr_d  = d_mem_addr;
      l2_wdata_d = d_mem_wdata;
      if (i_mem_read && starve_q != StarveMax) starve_d = starve_q + 1'b1;
    end
    if ((state_q == StGrantI || state_q == StGrantD) && l2_resp) begin
      l2_read_d  = 1'b0;
      l2_write_d = 1'b0;
      if (state_q == StGrantI) begin
        i_rdata_d = l2_rdata;
        i_resp_d  = 1'b1;
      end else begin
        d_rdata_d = l2_rdata;
        d_resp_d  = 1'b1;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
      l2_addr_q  <= '0;
      l2_wdata_q <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_resp_q   <= 1'b0;
      d_resp_q   <= 1'b0;
      starve_q   <= '0;
    end else begin
      l2_read_q  <= l2_read_d;
      l2_write_q <= l2_write_d;
      l2_addr_q  <= l2_addr_d;
      l2_wdata_q <= l2_wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_resp_q   <= i_resp_d;
      d_resp_q   <= d_resp_d;
      starve_q   <= starve_d;
    end
  end

  assign l2_read     = l2_read_q;
  assign l2_write    = l2_write_q;
  assign l2_addr     = l2_addr_q;
  assign l2_wdata    = l2_wdata_q;
  assign i_mem_rdata = i_rdata_q;
  assign d_mem_rdata = d_rdata_q;
  assign i_mem_resp  = i_resp_q;
  assign d_mem_resp  = d_resp_q;

`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0] i_grant_cnt_q, d_grant_cnt_q, contend_cnt_q;

  // Free-running, wrapping performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      i_grant_cnt_q <= '0;
      d_grant_cnt_q <= '0;
      contend_cnt_q <= '0;
    end else begin
      if (grant_i) i_grant_cnt_q <= i_grant_cnt_q + 1'b1;
      if (grant_d) d_grant_cnt_q <= d_grant_cnt_q + 1'b1;
      if (state_q == StIdle && i_mem_read && d_req) contend_cnt_q <= contend_cnt_q + 1'b1;
    end
  end

  assign i_grant_cnt = i_grant_cnt_q;
  assign d_grant_cnt = d_grant_cnt_q;
  assign contend_cnt = contend_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a queue-based scoreboard and an L2 responder.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_mem_read;
  logic [15:0]  i_mem_addr;
  logic [127:0] i_mem_rdata;
  logic         i_mem_resp;
  logic         d_mem_read, d_mem_write;
  logic [15:0]  d_mem_addr;
  logic [127:0] d_mem_wdata, d_mem_rdata;
  logic         d_mem_resp;
  logic         l2_read, l2_write;
  logic [15:0]  l2_addr;
  logic [127:0] l2_wdata, l2_rdata;
  logic         l2_resp;
`ifdef ARB_PERF_CNT_EN
  logic [15:0]  i_grant_cnt, d_grant_cnt, contend_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mem_port_arbiter #(
    .ADDR_W(16),
    .LINE_W(128),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp)
`ifdef ARB_PERF_CNT_EN
    ,
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .contend_cnt(contend_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           side_d;
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } exp_t;

  typedef struct {
    bit           ok;
    bit           rd;
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    int           strobe_cyc;
    int           resp_cyc;
    bit           resp_i;
    bit           resp_d;
    logic [127:0] rdata_i;
    logic [127:0] rdata_d;
    bit           strobe_after;
    bit           resp_after;
    bit           excl_bad;
  } txn_t;

  exp_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // L2 model: waits (bounded) for a strobe, answers after dly cycles, records what it saw.
  // Unless hold is set, the served requester drops its request on its resp pulse.
  task automatic l2_txn(input int dly, input logic [127:0] rd, input bit hold, output txn_t t);
    t = '{default: 0};
    for (int k = 0; k < 20 && !(l2_read || l2_write); k++) step();
    if (!(l2_read || l2_write)) return;
    t.strobe_cyc = cyc;
    t.rd         = l2_read;
    t.wr         = l2_write;
    t.addr       = l2_addr;
    t.wdata      = l2_wdata;
    t.excl_bad   = l2_read && l2_write;
    repeat (dly) step();
    l2_rdata = rd;
    l2_resp  = 1'b1;
    step();
    l2_resp  = 1'b0;
    l2_rdata = '0;
    t.resp_cyc     = cyc;
    t.resp_i       = i_mem_resp;
    t.resp_d       = d_mem_resp;
    t.rdata_i      = i_mem_rdata;
    t.rdata_d      = d_mem_rdata;
    t.strobe_after = l2_read || l2_write;
    t.excl_bad     = t.excl_bad || (i_mem_resp && d_mem_resp);
    if (!hold) begin
      if (i_mem_resp) i_mem_read = 1'b0;
      if (d_mem_resp) begin
        if (t.wr) d_mem_write = 1'b0;
        else      d_mem_read  = 1'b0;
      end
    end
    step();
    t.resp_after = i_mem_resp || d_mem_resp;
    t.ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_mem_read = 0; d_mem_read = 0; d_mem_write = 0; l2_resp = 0;
    i_mem_addr = '0; d_mem_addr = '0; d_mem_wdata = '0; l2_rdata = '0;
    repeat (3) step();
    checks++;
    if ({l2_read, l2_write, i_mem_resp, d_mem_resp} !== 4'b0) begin
      failures++;
      $display("FAIL reset_strobes: got %b want 0000", {l2_read, l2_write, i_mem_resp, d_mem_resp});
    end
    checks++;
    if (l2_addr !== 16'h0 || l2_wdata !== 128'h0) begin
      failures++; $display("FAIL reset_l2_regs: got %h/%h want 0/0", l2_addr, l2_wdata);
    end
    checks++;
    if (i_mem_rdata !== 128'h0 || d_mem_rdata !== 128'h0) begin
      failures++; $display("FAIL reset_rdata: got %h/%h want 0/0", i_mem_rdata, d_mem_rdata);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_lone_i_read();
    exp_t e; txn_t t; int c0;
    e = '{side_d: 0, wr: 0, addr: 16'h1230, wdata: '0, rdata: rand_line()};
    sb.push_back(e);
    i_mem_addr = e.addr; i_mem_read = 1'b1; c0 = cyc;
    l2_txn(2, sb[0].rdata, 1'b0, t);
    e = sb.pop_front();
    checks++;
    if (t.ok !== 1'b1) begin failures++; $display("FAIL i_timeout: got %0d want 1", t.ok); end
    checks++;
    if (t.strobe_cyc - c0 !== 1) begin
      failures++; $display("FAIL i_strobe_cyc: got %0d want 1", t.strobe_cyc - c0);
    end
    checks++;
    if ({t.rd, t.wr} !== 2'b10 || t.addr !== e.addr) begin
      failures++; $display("FAIL i_op_addr: got %b %h want 10 %h", {t.rd, t.wr}, t.addr, e.addr);
    end
    checks++;
    if (t.resp_cyc - c0 !== 4) begin
      failures++; $display("FAIL i_resp_cyc: got %0d want 4", t.resp_cyc - c0);
    end
    checks++;
    if ({t.resp_i, t.resp_d} !== 2'b10 || t.rdata_i !== e.rdata) begin
      failures++;
      $display("FAIL i_resp_data: got %b %h want 10 %h", {t.resp_i, t.resp_d}, t.rdata_i, e.rdata);
    end
    checks++;
    if (t.strobe_after !== 1'b0 || t.resp_after !== 1'b0) begin
      failures++;
      $display("FAIL i_one_shot: got strobe=%b resp=%b want 0 0", t.strobe_after, t.resp_after);
    end
  endtask

  task automatic test_lone_d_write();
    exp_t e; txn_t t; logic [127:0] i_keep;
    i_keep = i_mem_rdata;
    e = '{side_d: 1, wr: 1, addr: 16'h0040, wdata: {16{8'hA5}}, rdata: rand_line()};
    sb.push_back(e);
    d_mem_addr = e.addr; d_mem_wdata = e.wdata; d_mem_write = 1'b1;
    step();
    // Requester drops mid-transaction and scribbles its inputs; the latched copy must survive
    d_mem_write = 1'b0; d_mem_addr = 16'hFFFF; d_mem_wdata = '1;
    l2_txn(1, sb[0].rdata, 1'b0, t);
    e = sb.pop_front();
    checks++;
    if ({t.ok, t.rd, t.wr} !== 3'b101) begin
      failures++; $display("FAIL d_wr_op: got %b want 101", {t.ok, t.rd, t.wr});
    end
    checks++;
    if (t.addr !== e.addr || t.wdata !== e.wdata) begin
      failures++; $display("FAIL d_wr_latch: got %h %h want %h %h", t.addr, t.wdata, e.addr, e.wdata);
    end
    checks++;
    if ({t.resp_i, t.resp_d, t.resp_after} !== 3'b010) begin
      failures++; $display("FAIL d_wr_resp: got %b want 010", {t.resp_i, t.resp_d, t.resp_after});
    end
    checks++;
    if (i_mem_rdata !== i_keep) begin
      failures++; $display("FAIL i_rdata_hold: got %h want %h", i_mem_rdata, i_keep);
    end
  endtask

  task automatic test_stray_resp();
    logic [127:0] i_keep, d_keep;
    i_keep = i_mem_rdata; d_keep = d_mem_rdata;
    l2_rdata = rand_line(); l2_resp = 1'b1;
    step();
    l2_resp = 1'b0; l2_rdata = '0;
    step();
    checks++;
    if ({l2_read, l2_write, i_mem_resp, d_mem_resp} !== 4'b0 ||
        i_mem_rdata !== i_keep || d_mem_rdata !== d_keep) begin
      failures++;
      $display("FAIL stray_resp: got %b want 0000 (rdata changed=%b)",
               {l2_read, l2_write, i_mem_resp, d_mem_resp},
               (i_mem_rdata !== i_keep) || (d_mem_rdata !== d_keep));
    end
  endtask

  task automatic test_starvation();
    exp_t e; txn_t t; int prev_resp;
    bit order [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
    prev_resp = 0;
    foreach (order[k]) sb.push_back('{side_d: order[k], wr: 0,
                                       addr: order[k] ? 16'h3000 : 16'h2000,
                                       wdata: '0, rdata: rand_line()});
    i_mem_addr = 16'h2000; d_mem_addr = 16'h3000;
    i_mem_read = 1'b1; d_mem_read = 1'b1;
    for (int k = 0; k < 11; k++) begin
      l2_txn(0, sb[0].rdata, 1'b1, t);
      e = sb.pop_front();
      checks++;
      if (t.ok !== 1'b1 || {t.resp_i, t.resp_d} !== {~e.side_d, e.side_d} || t.addr !== e.addr) begin
        failures++;
        $display("FAIL starve_order[%0d]: got resp_i/d=%b%b addr=%h want %b%b addr=%h",
                 k, t.resp_i, t.resp_d, t.addr, ~e.side_d, e.side_d, e.addr);
      end
      checks++;
      if (t.excl_bad !== 1'b0 || t.wr !== 1'b0) begin
        failures++; $display("FAIL starve_excl[%0d]: got %b%b want 00", k, t.excl_bad, t.wr);
      end
      if (k > 0) begin
        checks++;
        if (t.strobe_cyc - prev_resp !== 2) begin
          failures++;
          $display("FAIL back_to_back[%0d]: got gap %0d want 2", k, t.strobe_cyc - prev_resp);
        end
      end
      prev_resp = t.resp_cyc;
    end
    i_mem_read = 1'b0; d_mem_read = 1'b0;
    step();
  endtask

  task automatic test_rw_both();
    exp_t e; txn_t t1, t2;
    sb.push_back('{side_d: 1, wr: 1, addr: 16'h0080, wdata: rand_line(), rdata: '0});
    sb.push_back('{side_d: 1, wr: 0, addr: 16'h0080, wdata: '0, rdata: rand_line()});
    d_mem_addr = 16'h0080; d_mem_wdata = sb[0].wdata;
    d_mem_read = 1'b1; d_mem_write = 1'b1;
    l2_txn(1, sb[0].rdata, 1'b0, t1);
    e = sb.pop_front();
    checks++;
    if ({t1.ok, t1.rd, t1.wr, t1.resp_d} !== 4'b1011 || t1.wdata !== e.wdata) begin
      failures++;
      $display("FAIL rw_first_write: got %b %h want 1011 %h",
               {t1.ok, t1.rd, t1.wr, t1.resp_d}, t1.wdata, e.wdata);
    end
    l2_txn(0, sb[0].rdata, 1'b0, t2);
    e = sb.pop_front();
    checks++;
    if ({t2.ok, t2.rd, t2.wr, t2.resp_d} !== 4'b1101 || t2.rdata_d !== e.rdata) begin
      failures++;
      $display("FAIL rw_then_read: got %b %h want 1101 %h",
               {t2.ok, t2.rd, t2.wr, t2.resp_d}, t2.rdata_d, e.rdata);
    end
    checks++;
    if (t2.strobe_cyc - t1.resp_cyc !== 2) begin
      failures++; $display("FAIL rw_gap: got %0d want 2", t2.strobe_cyc - t1.resp_cyc);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; txn_t t; int c0;
    d_mem_addr = 16'h0100; d_mem_read = 1'b1;
    step();
    checks++;
    if (l2_read !== 1'b1) begin failures++; $display("FAIL mid_grant: got %b want 1", l2_read); end
    rst = 1'b1; d_mem_read = 1'b0;
    step();
    rst = 1'b0;
    checks++;
    if ({l2_read, l2_write, d_mem_resp, i_mem_resp} !== 4'b0 || d_mem_rdata !== 128'h0) begin
      failures++;
      $display("FAIL mid_reset: got %b %h want 0000 0",
               {l2_read, l2_write, d_mem_resp, i_mem_resp}, d_mem_rdata);
    end
    step();
    checks++;
    if ({l2_read, l2_write, d_mem_resp} !== 3'b0) begin
      failures++; $display("FAIL mid_no_resp: got %b want 000", {l2_read, l2_write, d_mem_resp});
    end
    e = '{side_d: 0, wr: 0, addr: 16'h4440, wdata: '0, rdata: rand_line()};
    sb.push_back(e);
    i_mem_addr = e.addr; i_mem_read = 1'b1; c0 = cyc;
    l2_txn(1, sb[0].rdata, 1'b0, t);
    e = sb.pop_front();
    checks++;
    if (t.ok !== 1'b1 || t.strobe_cyc - c0 !== 1 || t.addr !== e.addr ||
        t.resp_i !== 1'b1 || t.rdata_i !== e.rdata) begin
      failures++;
      $display("FAIL mid_fresh: got ok=%b dly=%0d addr=%h resp=%b rdata=%h want 1 1 %h 1 %h",
               t.ok, t.strobe_cyc - c0, t.addr, t.resp_i, t.rdata_i, e.addr, e.rdata);
    end
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf();
    txn_t t;
    rst = 1'b1; step(); rst = 1'b0;
    i_mem_addr = 16'h5000; d_mem_addr = 16'h6000;
    for (int r = 0; r < 2; r++) begin
      i_mem_read = 1'b1; d_mem_read = 1'b1;
      l2_txn(0, rand_line(), 1'b0, t);
      l2_txn(0, rand_line(), 1'b0, t);
    end
    i_mem_read = 1'b1;
    l2_txn(0, rand_line(), 1'b0, t);
    checks++;
    if (i_grant_cnt !== 16'd3 || d_grant_cnt !== 16'd2 || contend_cnt !== 16'd2) begin
      failures++;
      $display("FAIL perf_cnt: got %0d %0d %0d want 3 2 2", i_grant_cnt, d_grant_cnt, contend_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lone_i_read();
    test_lone_d_write();
    test_stray_resp();
    test_starvation();
    test_rw_both();
    test_reset_mid();
`ifdef ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
